memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/y86_pkg.sv | 26 ++
 rtl/data_mem.sv | 33 +++
 rtl/memory_stage.sv | 120 ++++++++++++
 tb/tb_memory_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 icodes, register ids, status codes and memory size default
package y86_pkg;

  localparam int DMEM_BYTES_DEF = 1024;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte array with 8-byte little-endian async read and sync write
module data_mem #(
  parameter int BYTES = 1024,
  parameter int AW    = $clog2(BYTES)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  // Contents are deliberately never reset; they only change through writes.
  logic [7:0] r_mem [BYTES];

  // Combinational read of 8 consecutive bytes, lowest address in the low byte.
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      o_rdata[8*k +: 8] = r_mem[i_addr + AW'(k)];
    end
  end

  // Store 8 bytes little-endian; reads this cycle still see the old bytes.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[i_addr + AW'(k)] <= i_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage with data memory access and W pipeline register
module memory_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = DMEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  M_icode,
  input  logic [2:0]  M_stat,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic [3:0]  W_icode,
  output logic [2:0]  W_stat,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam int          AW        = $clog2(DMEM_BYTES);
  localparam logic [63:0] LAST_ADDR = 64'(DMEM_BYTES - 8);

  logic [63:0] w_addr;
  logic        w_read;
  logic        w_write;
  logic        w_dmem_error;
  logic        w_we;
  logic [63:0] w_rdata;

  logic [3:0]  r_icode;
  logic [2:0]  r_stat;
  logic [63:0] r_valE;
  logic [63:0] r_valM;
  logic [3:0]  r_dstE;
  logic [3:0]  r_dstM;

  // Decode address source and access direction from the icode.
  always_comb begin
    w_addr  = '0;
    w_read  = 1'b0;
    w_write = 1'b0;
    case (M_icode)
      I_POPQ, I_RET: begin
        w_addr = M_valA;
        w_read = 1'b1;
      end
      I_MRMOVQ: begin
        w_addr = M_valE;
        w_read = 1'b1;
      end
      I_RMMOVQ, I_PUSHQ, I_CALL: begin
        w_addr  = M_valE;
        w_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Full 64-bit compare so huge addresses never alias into the array.
  assign w_dmem_error = (w_read || w_write) && (w_addr > LAST_ADDR);
  assign m_stat       = w_dmem_error ? SADR : M_stat;
  assign m_valM       = (w_read && !w_dmem_error) ? w_rdata : '0;

  // Writes ignore W_stall/W_bubble but are dropped while reset is held.
  assign w_we = w_write && !w_dmem_error && (M_stat == SAOK) && rst_n;

  data_mem #(
    .BYTES (DMEM_BYTES),
    .AW    (AW)
  ) u_data_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr[AW-1:0]),
    .i_wdata (M_valA),
    .o_rdata (w_rdata)
  );

  // W pipeline register: reset/bubble load a NOP, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icode <= I_NOP;
      r_stat  <= SAOK;
      r_valE  <= '0;
      r_valM  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
    end else if (W_stall) begin
      r_icode <= r_icode;
    end else if (W_bubble) begin
      r_icode <= I_NOP;
      r_stat  <= SAOK;
      r_valE  <= '0;
      r_valM  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
    end else begin
      r_icode <= M_icode;
      r_stat  <= m_stat;
      r_valE  <= M_valE;
      r_valM  <= m_valM;
      r_dstE  <= M_dstE;
      r_dstM  <= M_dstM;
    end
  end

  assign W_icode = r_icode;
  assign W_stat  = r_stat;
  assign W_valE  = r_valE;
  assign W_valM  = r_valM;
  assign W_dstE  = r_dstE;
  assign W_dstM  = r_dstM;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage against a reference model
module tb_memory_stage;

  localparam int DB = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  M_icode;
  logic [2:0]  M_stat;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic [63:0] m_valM;
  logic [2:0]  m_stat;
  logic [3:0]  W_icode;
  logic [2:0]  W_stat;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_mem [DB];
  logic [3:0]  e_icode;
  logic [2:0]  e_stat;
  logic [63:0] e_valE;
  logic [63:0] e_valM;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;

  memory_stage #(.DMEM_BYTES(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .M_icode  (M_icode),
    .M_stat   (M_stat),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM),
    .W_stall  (W_stall),
    .W_bubble (W_bubble),
    .m_valM   (m_valM),
    .m_stat   (m_stat),
    .W_icode  (W_icode),
    .W_stat   (W_stat),
    .W_valE   (W_valE),
    .W_valM   (W_valM),
    .W_dstE   (W_dstE),
    .W_dstM   (W_dstM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_rd(input logic [3:0] ic);
    return (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
  endfunction

  function automatic logic is_wr(input logic [3:0] ic);
    return (ic == 4'd4) || (ic == 4'd8) || (ic == 4'd10);
  endfunction

  function automatic logic [63:0] ref_addr(input logic [3:0] ic, input logic [63:0] ve,
                                           input logic [63:0] va);
    if (ic == 4'd9 || ic == 4'd11) return va;
    if (ic == 4'd4 || ic == 4'd5 || ic == 4'd8 || ic == 4'd10) return ve;
    return 64'd0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a);
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v = v | (64'(ref_mem[int'(a) + k]) << (8 * k));
    return v;
  endfunction

  task automatic set_bubble_model();
    e_icode = 4'd1; e_stat = 3'd1; e_valE = '0; e_valM = '0; e_dstE = 4'd15; e_dstM = 4'd15;
  endtask

  // One instruction: drive, check combinational outputs, clock, check W register.
  task automatic cycle(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                       input logic stall, input logic bubble);
    logic [63:0] a;
    logic        acc, err;
    logic [2:0]  x_stat;
    logic [63:0] x_valm;
    M_icode = ic; M_stat = st; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
    W_stall = stall; W_bubble = bubble;
    #1;
    a      = ref_addr(ic, ve, va);
    acc    = is_rd(ic) || is_wr(ic);
    err    = acc && (a > 64'(DB - 8));
    x_stat = err ? 3'd3 : st;
    x_valm = (is_rd(ic) && !err) ? ref_load(a) : 64'd0;
    chk("m_stat", 64'(m_stat), 64'(x_stat));
    chk("m_valM", m_valM, x_valm);
    @(posedge clk);
    if (!rst_n) begin
      set_bubble_model();
    end else begin
      if (is_wr(ic) && !err && st == 3'd1)
        for (int k = 0; k < 8; k++) ref_mem[int'(a) + k] = va[8*k +: 8];
      if (!stall) begin
        if (bubble) set_bubble_model();
        else begin
          e_icode = ic; e_stat = x_stat; e_valE = ve; e_valM = x_valm; e_dstE = de; e_dstM = dm;
        end
      end
    end
    #1;
    chk("W_icode", 64'(W_icode), 64'(e_icode));
    chk("W_stat",  64'(W_stat),  64'(e_stat));
    chk("W_valE",  W_valE, e_valE);
    chk("W_valM",  W_valM, e_valM);
    chk("W_dstE",  64'(W_dstE),  64'(e_dstE));
    chk("W_dstM",  64'(W_dstM),  64'(e_dstM));
  endtask

  task automatic chk_bubble_now(input string tag);
    chk({tag, "_icode"}, 64'(W_icode), 64'd1);
    chk({tag, "_stat"},  64'(W_stat),  64'd1);
    chk({tag, "_valE"},  W_valE, 64'd0);
    chk({tag, "_valM"},  W_valM, 64'd0);
    chk({tag, "_dstE"},  64'(W_dstE),  64'd15);
    chk({tag, "_dstM"},  64'(W_dstM),  64'd15);
  endtask

  function automatic logic [63:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 6) return 64'($urandom_range(0, DB - 8));
    if (r == 6) return 64'(DB - 8 + $urandom_range(0, 15));
    if (r == 7) return {$urandom, $urandom};
    return 64'($urandom_range(0, 63));
  endfunction

  initial begin
    for (int i = 0; i < DB; i++) ref_mem[i] = 8'h00;
    M_icode = 4'd1; M_stat = 3'd1; M_valE = '0; M_valA = '0; M_dstE = 4'd15; M_dstM = 4'd15;
    W_stall = 1'b0; W_bubble = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_bubble_now("reset_async");
    set_bubble_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Bring the whole array to a known zero state.
    for (int a = 0; a <= DB - 8; a += 8) cycle(4'd4, 3'd1, 64'(a), 64'd0, 4'd15, 4'd15, 1'b0, 1'b0);

    // Store then load, one-edge latency into W.
    cycle(4'd4, 3'd1, 64'h40, 64'h1122334455667788, 4'd15, 4'd15, 1'b0, 1'b0);
    cycle(4'd5, 3'd1, 64'h40, 64'd0, 4'd15, 4'd3, 1'b0, 1'b0);
    chk("store_load_W_valM", W_valM, 64'h1122334455667788);
    chk("byte_0x40", 64'(W_valM[7:0]), 64'h88);

    // Address boundaries.
    cycle(4'd5, 3'd1, 64'(DB - 8), 64'd0, 4'd15, 4'd2, 1'b0, 1'b0);
    chk("bound_last_ok", 64'(W_stat), 64'd1);
    cycle(4'd5, 3'd1, 64'(DB - 7), 64'd0, 4'd15, 4'd2, 1'b0, 1'b0);
    chk("bound_over_sadr", 64'(W_stat), 64'd3);
    cycle(4'd5, 3'd1, 64'hFFFFFFFFFFFFFFFC, 64'd0, 4'd15, 4'd2, 1'b0, 1'b0);
    chk("bound_wrap_sadr", 64'(W_stat), 64'd3);

    // Out-of-range push must not alias onto low addresses.
    cycle(4'd10, 3'd1, 64'h2000, 64'hDEADBEEFCAFEF00D, 4'd4, 4'd15, 1'b0, 1'b0);
    chk("err_push_sadr", 64'(W_stat), 64'd3);
    cycle(4'd5, 3'd1, 64'h0, 64'd0, 4'd15, 4'd1, 1'b0, 1'b0);
    cycle(4'd5, 3'd1, 64'h40, 64'd0, 4'd15, 4'd1, 1'b0, 1'b0);

    // Stall, bubble and both together.
    cycle(4'd5, 3'd1, 64'h40, 64'd0, 4'd15, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'd6, 3'd1, 64'h7, 64'h9, 4'd2, 4'd15, 1'b1, 1'b0);
      chk("stall_hold", 64'(W_icode), 64'd5);
    end
    cycle(4'd6, 3'd1, 64'h7, 64'h9, 4'd2, 4'd15, 1'b0, 1'b1);
    chk("bubble_icode", 64'(W_icode), 64'd1);
    chk("bubble_dstE", 64'(W_dstE), 64'd15);
    cycle(4'd2, 3'd1, 64'h55, 64'h0, 4'd6, 4'd15, 1'b0, 1'b0);
    cycle(4'd6, 3'd1, 64'h7, 64'h9, 4'd2, 4'd15, 1'b1, 1'b1);
    chk("stall_wins", 64'(W_icode), 64'd2);

    // Mid-cycle reset after a pop; write under reset is suppressed; memory retained.
    cycle(4'd11, 3'd1, 64'h48, 64'h40, 4'd4, 4'd5, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_bubble_now("reset_mid");
    set_bubble_model();
    cycle(4'd4, 3'd1, 64'h40, 64'hAAAAAAAAAAAAAAAA, 4'd15, 4'd15, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(4'd5, 3'd1, 64'h40, 64'd0, 4'd15, 4'd3, 1'b0, 1'b0);
    chk("mem_retained", W_valM, 64'h1122334455667788);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 4)) : 3'd1;
      cycle(4'($urandom_range(0, 11)), st, rand_addr(), ($urandom_range(0, 1) == 0) ? rand_addr() : {$urandom, $urandom},
            4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
